multi_debounce: RTL and testbench
=================================

// Module: multi_debounce
// PURPOSE
//  Parametrised N-channel debouncer for buttons/switches and slow status pins (e.g. MAX3421E INT/GPX).
//  - Each channel: 2-FF synchroniser, own stability counter, registered debounced level.
//  - Generates one-cycle rise/fall event pulses per channel.
//  - Optional hold/auto-repeat pulse generator per channel.
//  - Sits between raw board pins and the control FSMs/registers.
// PARAMETERS
//  CHANNELS       4      number of independent input channels (>=1)
//  CNT_W          16     stability counter width per channel
//  STABLE_CYCLES  1024   consecutive differing cycles required before db_out changes (2..2^CNT_W)
//  INIT_LEVEL     1'b0   reset value of sync FFs and db_out (all channels)
//  HOLD_W         24     hold/repeat counter width (used only with HOLD_REPEAT_EN)
//  HOLD_CYCLES    2**20  cycles db_out must stay 1 before first hold_pulse (>=1, <2^HOLD_W)
//  REPEAT_CYCLES  2**18  cycles between subsequent hold_pulses (>=1, <2^HOLD_W)
// PORTS
//  clk         in   1         system clock, all logic on rising edge
//  reset       in   1         synchronous reset, active-high
//  button_in   in   CHANNELS  raw asynchronous inputs
//  db_out      out  CHANNELS  debounced levels (registered)
//  rise_pulse  out  CHANNELS  1-cycle pulse, same edge db_out goes 0->1
//  fall_pulse  out  CHANNELS  1-cycle pulse, same edge db_out goes 1->0
//  hold_pulse  out  CHANNELS  1-cycle hold/repeat pulse (constant 0 without HOLD_REPEAT_EN)
// BEHAVIOUR
//  - Reset (reset=1 at edge): s1, s2, db_out = INIT_LEVEL; cnt, hold_cnt = 0; rise/fall/hold_pulse = 0.
//  - Reset dominates everything; mid-count reset discards progress.
//  - No pulse on the first edge after reset, even if the input differs.
//  - Per channel i, every edge: s1 <= button_in[i]; s2 <= s1.
//  - s2 == db_out: cnt <= 0; no event.
//  - s2 != db_out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
//  - s2 != db_out and cnt == STABLE_CYCLES-1: db_out <= s2; cnt <= 0; rise_pulse or fall_pulse <= 1 for that cycle.
//  - Pulses are registered; they deassert on the next edge.
//  - Latency: input level stable from edge 0 -> db_out updates on edge STABLE_CYCLES+1.
//  - Any bounce that returns s2 to db_out before the threshold clears cnt: no output change, no pulse.
//  - cnt never exceeds STABLE_CYCLES-1; no wrap possible.
//  - Channels are fully independent; simultaneous events on several channels all pulse on the same edge.
//  - rise_pulse[i] and fall_pulse[i] are never both 1.
//  - Parameter legality is checked at elaboration ($error):
//      STABLE_CYCLES outside 2..2^CNT_W; HOLD_CYCLES or REPEAT_CYCLES outside 1..2^HOLD_W-1.
// CONFIGURATION
//  HOLD_REPEAT_EN defined:
//  - hold_cnt clears on every edge where db_out is 0, and on the rise edge.
//  - While db_out stays 1, hold_cnt increments each edge.
//  - hold_cnt == HOLD_CYCLES: hold_pulse = 1 for one cycle.
//      Hold pulse at edge E if the rise was at edge E-HOLD_CYCLES.
//  - Thereafter a hold_pulse every REPEAT_CYCLES edges while db_out remains 1:
//      hold_cnt reloads to HOLD_CYCLES-REPEAT_CYCLES+1 ... equivalent spacing.
//  - Fall clears hold_cnt; no hold_pulse on or after the fall edge.
//  HOLD_REPEAT_EN undefined: hold counters are not built; hold_pulse tied to 0.
// TESTING
//  1. Reset with button_in=4'hF, INIT_LEVEL=0
//     -> db_out=0, all pulses 0 during reset and on the first edge after.
//  2. STABLE_CYCLES=8: ch0 0->1 held from edge 0
//     -> db_out[0]=1 and rise_pulse[0]=1 at edge 9 only; other channels unchanged.
//  3. ch1 bounce: high 5 cycles, low 2, high 20 (STABLE_CYCLES=8)
//     -> single rise_pulse, 9 edges after the final rising level; no fall_pulse.
//  4. ch2, ch3 toggle on the same edge (ch2 0->1, ch3 1->0)
//     -> rise_pulse[2] and fall_pulse[3] on the same edge.
//  5. Reset asserted mid-count (cnt=5, STABLE_CYCLES=8)
//     -> db_out stays INIT_LEVEL; after release a full 8-cycle count is needed again.
//  6. HOLD_REPEAT_EN, HOLD_CYCLES=16, REPEAT_CYCLES=4, ch0 held high 40 cycles after rise
//     -> hold_pulse at rise+16, +20, +24, ... +40; none after fall.

Source files
------------

// File: rtl/multi_debounce.sv
// N-channel debouncer: 2-FF synchroniser, per-channel stability counter, rise/fall pulses.
// Optional hold/auto-repeat pulse generator enabled by defining HOLD_REPEAT_EN.
module multi_debounce #(
    parameter int   CHANNELS      = 4,
    parameter int   CNT_W         = 16,
    parameter int   STABLE_CYCLES = 1024,
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   HOLD_W        = 24,
    parameter int   HOLD_CYCLES   = 2**20,
    parameter int   REPEAT_CYCLES = 2**18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse
);

    if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_stable
        $error("multi_debounce: STABLE_CYCLES out of range 2..2^CNT_W");
    end
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) >= (longint'(1) << HOLD_W)) begin : g_bad_hold
        $error("multi_debounce: HOLD_CYCLES out of range 1..2^HOLD_W-1");
    end
    if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) >= (longint'(1) << HOLD_W)) begin : g_bad_repeat
        $error("multi_debounce: REPEAT_CYCLES out of range 1..2^HOLD_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] s1_q, s2_q;
    logic [CHANNELS-1:0] db_q, db_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]   = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= {CHANNELS{INIT_LEVEL}};
            s2_q   <= {CHANNELS{INIT_LEVEL}};
            db_q   <= {CHANNELS{INIT_LEVEL}};
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= button_in;
            s2_q   <= s1_q;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef HOLD_REPEAT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] REP_LIM  = HOLD_W'(REPEAT_CYCLES);

    logic [HOLD_W-1:0]   hold_cnt_q [CHANNELS];
    logic [HOLD_W-1:0]   hold_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rep_q, rep_d;
    logic [CHANNELS-1:0] hold_q, hold_d;

    // A repeat-phase flag switches the terminal count from HOLD to REPEAT instead of
    // reloading to HOLD-REPEAT+1, so REPEAT_CYCLES > HOLD_CYCLES cannot underflow.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            hold_cnt_d[i] = '0;
            rep_d[i]      = 1'b0;
            hold_d[i]     = 1'b0;
            if (db_q[i] && db_d[i]) begin
                if (hold_cnt_q[i] == (rep_q[i] ? REP_LIM : HOLD_LIM)) begin
                    hold_cnt_d[i] = HOLD_W'(1);
                    rep_d[i]      = 1'b1;
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    rep_d[i]      = rep_q[i];
                end
                hold_d[i] = (hold_cnt_d[i] == (rep_d[i] ? REP_LIM : HOLD_LIM));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q  <= '0;
            hold_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                hold_cnt_q[i] <= '0;
            end
        end else begin
            rep_q  <= rep_d;
            hold_q <= hold_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign hold_pulse = hold_q;
`else
    assign hold_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_debounce.sv
// Directed self-checking bench for multi_debounce (STABLE_CYCLES=8, HOLD 16 / REPEAT 4).
module tb_multi_debounce;

`ifdef HOLD_REPEAT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] button_in = 4'h0;
    logic [3:0] db_out, rise_pulse, fall_pulse, hold_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    multi_debounce #(
        .CHANNELS      (4),
        .CNT_W         (16),
        .STABLE_CYCLES (8),
        .INIT_LEVEL    (1'b0),
        .HOLD_W        (24),
        .HOLD_CYCLES   (16),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button_in  (button_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .hold_pulse (hold_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all inputs high: nothing may leak through.
        reset     = 1'b1;
        button_in = 4'hF;
        tick();
        tick();
        check("rst_db",   db_out,     4'h0);
        check("rst_rise", rise_pulse, 4'h0);
        check("rst_fall", fall_pulse, 4'h0);
        check("rst_hold", hold_pulse, 4'h0);
        reset = 1'b0;
        tick();
        check("first_db",   db_out,     4'h0);
        check("first_rise", rise_pulse, 4'h0);
        check("first_fall", fall_pulse, 4'h0);

        reset     = 1'b1;
        button_in = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // ch0 rise: update on edge 9 counted from the first sampling edge.
        button_in = 4'b0001;
        for (int e = 0; e <= 10; e++) begin
            tick();
            check("t2_db",   db_out,     (e >= 9) ? 4'b0001 : 4'b0000);
            check("t2_rise", rise_pulse, (e == 9) ? 4'b0001 : 4'b0000);
            check("t2_fall", fall_pulse, 4'b0000);
        end

        // ch1 bounce: 5 high, 2 low, then steady high.
        button_in = 4'b0011;
        repeat (5) begin
            tick();
            check("t3_bounce_rise", rise_pulse, 4'b0000);
        end
        button_in = 4'b0001;
        repeat (2) begin
            tick();
            check("t3_bounce_rise", rise_pulse, 4'b0000);
            check("t3_bounce_db",   db_out,     4'b0001);
        end
        button_in = 4'b0011;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("t3_rise", rise_pulse, (e == 9) ? 4'b0010 : 4'b0000);
            check("t3_fall", fall_pulse, 4'b0000);
        end
        check("t3_db", db_out, 4'b0011);

        // ch3 up first, then ch2 rises while ch3 falls on the same edge.
        button_in = 4'b1011;
        repeat (12) tick();
        check("t4_pre_db", db_out, 4'b1011);
        button_in = 4'b0111;
        for (int e = 0; e <= 10; e++) begin
            tick();
            check("t4_rise", rise_pulse, (e == 9) ? 4'b0100 : 4'b0000);
            check("t4_fall", fall_pulse, (e == 9) ? 4'b1000 : 4'b0000);
        end
        check("t4_db", db_out, 4'b0111);

        // Reset with ch3 mid-count (cnt=5), then a full count after release.
        button_in = 4'b1111;
        repeat (7) tick();
        check("t5_mid_db", db_out, 4'b0111);
        reset = 1'b1;
        tick();
        check("t5_rst_db",   db_out,     4'b0000);
        check("t5_rst_rise", rise_pulse, 4'b0000);
        reset = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check("t5_db",   db_out,     (e == 9) ? 4'hF : 4'h0);
            check("t5_rise", rise_pulse, (e == 9) ? 4'hF : 4'h0);
            check("t5_hold", hold_pulse, 4'h0);
        end

        // Hold/repeat: rise at edge R above; pulses at R+16, +20, ... while high.
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("t6_db",   db_out,     4'hF);
            check("t6_hold", hold_pulse,
                  (HOLD_EN && k >= 16 && (k % 4) == 0) ? 4'hF : 4'h0);
        end
        button_in = 4'h0;
        for (int e = 0; e <= 11; e++) begin
            tick();
            check("t6_fall",      fall_pulse, (e == 9) ? 4'hF : 4'h0);
            check("t6_fall_hold", hold_pulse,
                  (HOLD_EN && e < 9 && ((41 + e) % 4) == 0) ? 4'hF : 4'h0);
        end
        check("t6_end_db", db_out, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
